// File: rtl/knn_topk_stream_selector.sv
// knn_topk_stream_selector: streaming top-K (distance, type) selector with a sorted register list.
// Optional macro KNN_TOPK_VOTE_EN adds a registered majority-vote output vote_type.
`default_nettype none

module knn_topk_stream_selector #(
  parameter int L      = 2,
  parameter int W      = 16,
  parameter int TYPE_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic                  ascending,
  input  logic [W-1:0]          in_key,
  input  logic [TYPE_W-1:0]     in_type,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W*(1<<L)-1:0]   out_key,
  output logic [TYPE_W*(1<<L)-1:0] out_type,
`ifdef KNN_TOPK_VOTE_EN
  output logic [TYPE_W-1:0]     vote_type,
`endif
  output logic [L:0]            out_count
);

  localparam int K = 1 << L;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [K-1:0][W-1:0]           key_q, key_d, key_sh;
  logic [K-1:0][TYPE_W-1:0]      type_q, type_d, type_sh;
  logic [L:0]                    count_q, count_d;
  logic                          first_q, first_d;
  logic                          mode_q, mode_d;

  logic                          mode_cur;
  logic                          accept;
  logic [W-1:0]                  fill_key;
  logic [K-1:0]                  worse, prev_worse;

  assign in_ready  = (state_q == ACCUM) & rst;
  assign out_valid = (state_q == HOLD);
  assign out_key   = key_q;
  assign out_type  = type_q;
  assign out_count = count_q;

  assign accept   = in_valid & in_ready;
  assign mode_cur = first_q ? ascending : mode_q;
  assign fill_key = mode_cur ? {W{1'b1}} : {W{1'b0}};
  assign key_sh   = {key_q[K-2:0], {W{1'b0}}};
  assign type_sh  = {type_q[K-2:0], {TYPE_W{1'b0}}};

  // Entries are packed best-first, so empties sit at the tail and worse[] is monotonic.
  always_comb begin
    worse = '0;
    for (int i = 0; i < K; i++) begin
      if (count_q <= (L+1)'(i)) begin
        worse[i] = 1'b1;
      end else if (mode_cur) begin
        worse[i] = key_q[i] > in_key;
      end else begin
        worse[i] = key_q[i] < in_key;
      end
    end
    prev_worse = {worse[K-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    type_d  = type_q;
    count_d = count_q;
    first_d = first_q;
    mode_d  = mode_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          first_d = 1'b0;
          mode_d  = mode_cur;
          for (int i = 0; i < K; i++) begin
            if (first_q && i != 0) begin
              key_d[i]  = fill_key;
              type_d[i] = '0;
            end else if (worse[i] && !prev_worse[i]) begin
              key_d[i]  = in_key;
              type_d[i] = in_type;
            end else if (worse[i]) begin
              key_d[i]  = key_sh[i];
              type_d[i] = type_sh[i];
            end
          end
          if (count_q != (L+1)'(K)) begin
            count_d = count_q + (L+1)'(1);
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          key_d   = '0;
          type_d  = '0;
          count_d = '0;
          first_d = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      key_q   <= '0;
      type_q  <= '0;
      count_q <= '0;
      first_q <= 1'b1;
      mode_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      type_q  <= type_d;
      count_q <= count_d;
      first_q <= first_d;
      mode_q  <= mode_d;
    end
  end

`ifdef KNN_TOPK_VOTE_EN
  localparam int NB = 1 << TYPE_W;

  logic [NB-1:0][L:0]  hist;
  logic [L:0]          best;
  logic [TYPE_W-1:0]   win;
  logic [TYPE_W-1:0]   vote_q, vote_d;

  // Vote is taken over the next-state list so it lands in the same edge as out_valid.
  always_comb begin
    hist = '0;
    for (int i = 0; i < K; i++) begin
      if (count_d > (L+1)'(i)) begin
        hist[type_d[i]] = hist[type_d[i]] + (L+1)'(1);
      end
    end
    best = '0;
    win  = '0;
    for (int b = 0; b < NB; b++) begin
      if (hist[b] > best) begin
        best = hist[b];
        win  = TYPE_W'(b);
      end
    end
    vote_d = vote_q;
    if (state_q == ACCUM && state_d == HOLD) begin
      vote_d = win;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_q <= '0;
    end else begin
      vote_q <= vote_d;
    end
  end

  assign vote_type = vote_q;
`endif

endmodule

`default_nettype wire
